// File: rtl/board_line_evaluator.sv
// Tic-tac-toe status evaluator: snapshots the 9-cell board on start, then scans
// the 8 winning lines one per clock and reports winner, line, draw and bad codes.
module board_line_evaluator #(
  parameter logic [1:0] EMPTY_CODE = 2'b00,
  parameter logic [1:0] P1_CODE    = 2'b01,
  parameter logic [1:0] P2_CODE    = 2'b10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       busy,
  output logic       done,
  output logic       status,
  output logic [1:0] winner,
  output logic [2:0] win_line,
  output logic       board_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx;
  logic [8:0][1:0] pos_all;
  logic [8:0][1:0] snap_p0;
  logic [1:0]      line_win;
  logic            board_full;
  logic            board_bad;

  assign pos_all = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  // Returns 2'b01 for a player line, 2'b10 for a PC line, 2'b00 otherwise.
  function automatic logic [1:0] line_owner(input logic [8:0][1:0] b, input logic [2:0] i);
    logic [3:0] ca, cb, cc;
    case (i)
      3'd0:    begin ca = 4'd0; cb = 4'd1; cc = 4'd2; end
      3'd1:    begin ca = 4'd3; cb = 4'd4; cc = 4'd5; end
      3'd2:    begin ca = 4'd6; cb = 4'd7; cc = 4'd8; end
      3'd3:    begin ca = 4'd0; cb = 4'd3; cc = 4'd6; end
      3'd4:    begin ca = 4'd1; cb = 4'd4; cc = 4'd7; end
      3'd5:    begin ca = 4'd2; cb = 4'd5; cc = 4'd8; end
      3'd6:    begin ca = 4'd0; cb = 4'd4; cc = 4'd8; end
      default: begin ca = 4'd2; cb = 4'd4; cc = 4'd6; end
    endcase
    line_owner = 2'b00;
    if (b[ca] == P1_CODE && b[cb] == P1_CODE && b[cc] == P1_CODE)
      line_owner = 2'b01;
    else if (b[ca] == P2_CODE && b[cb] == P2_CODE && b[cc] == P2_CODE)
      line_owner = 2'b10;
  endfunction

  function automatic logic cell_filled(input logic [1:0] c);
    return (c == P1_CODE) || (c == P2_CODE);
  endfunction

  function automatic logic cell_valid(input logic [1:0] c);
    return cell_filled(c) || (c == EMPTY_CODE);
  endfunction

  always_comb begin
    board_full = 1'b1;
    board_bad  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (!cell_filled(snap_p0[k])) board_full = 1'b0;
      if (!cell_valid(snap_p0[k]))  board_bad  = 1'b1;
    end
    line_win = line_owner(snap_p0, idx);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (line_win != 2'b00 || idx == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: board capture; results register on the edge that enters DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_p0     <= {9{EMPTY_CODE}};
      idx         <= 3'd0;
      status      <= 1'b0;
      winner      <= 2'b00;
      win_line    <= 3'd0;
      board_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_p0 <= pos_all;
            idx     <= 3'd0;
          end
        end
        SCAN: begin
          if (line_win != 2'b00) begin
            winner      <= line_win;
            win_line    <= idx;
            status      <= 1'b1;
            board_error <= board_bad;
          end else if (idx == 3'd7) begin
            winner      <= board_full ? 2'b11 : 2'b00;
            win_line    <= 3'd0;
            status      <= board_full;
            board_error <= board_bad;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
